// File: rtl/huffman_stream_encoder.sv
// Streaming Huffman encoder: run-time loadable code table, one-symbol lookup stage,
// MSB-first bit packer into OUT_W-bit words with valid/ready on both sides and flush.
module huffman_stream_encoder #(
  parameter int SYM_W   = 8,
  parameter int MAX_LEN = 16,
  parameter int OUT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   tbl_we,
  input  logic [SYM_W-1:0]       tbl_addr,
  input  logic [MAX_LEN-1:0]     tbl_code,
  input  logic [LEN_W-1:0]       tbl_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SYM_W-1:0]       data_in,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       data_out,
  output logic [$clog2(OUT_W):0] out_nbits,
  output logic                   out_last,
  output logic                   busy,
  output logic                   err_unmapped
);
  localparam int NB_W  = $clog2(OUT_W) + 1;
  localparam int ACC_W = OUT_W + MAX_LEN;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int DEPTH = 1 << SYM_W;
  localparam logic [CNT_W-1:0] OUT_WC = CNT_W'(OUT_W);
  localparam logic [LEN_W-1:0] MAX_LC = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] code_mem [DEPTH];
  logic [LEN_W-1:0]   len_mem  [DEPTH];

  logic               s1_valid;
  logic [MAX_LEN-1:0] s1_code;
  logic [LEN_W-1:0]   s1_len;
  logic [ACC_W-1:0]   acc, acc_d, placed;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               flush_pending;
  logic               out_free, drain, merge, fin, accept;

  // Codes are stored pre-masked so the packer can OR them in without a length mask.
  always_ff @(posedge clk) begin
    if (tbl_we && !busy) begin
      len_mem[tbl_addr]  <= (tbl_len > MAX_LC) ? '0 : tbl_len;
      code_mem[tbl_addr] <= tbl_code & ({MAX_LEN{1'b1}} >> (MAX_LC - tbl_len));
    end
  end

  always_comb begin
    out_free = !out_valid || out_ready;
    drain    = enable && (cnt >= OUT_WC) && out_free;
    acc_d    = drain ? (acc << OUT_W) : acc;
    cnt_d    = drain ? (cnt - OUT_WC) : cnt;
    merge    = enable && s1_valid && (cnt_d < OUT_WC);
    // Final word waits for the lookup stage to empty; out_last blocks a second emission.
    fin      = enable && flush_pending && !s1_valid && (cnt < OUT_WC) && out_free &&
               !(out_valid && out_last);
    in_ready = enable && !flush_pending && (!s1_valid || merge);
    accept   = in_valid && in_ready;
    // Left-justify the code, then slide it down to the current fill point.
    placed   = ({s1_code, {OUT_W{1'b0}}} << (MAX_LC - s1_len)) >> cnt_d;
  end

  assign busy = s1_valid || (cnt != '0) || out_valid || flush_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_code       <= '0;
      s1_len        <= '0;
      acc           <= '0;
      cnt           <= '0;
      flush_pending <= 1'b0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      data_out      <= '0;
      out_nbits     <= '0;
      err_unmapped  <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_code  <= code_mem[data_in];
        s1_len   <= len_mem[data_in];
      end else if (merge) begin
        s1_valid <= 1'b0;
      end

      if (merge && s1_len == '0) err_unmapped <= 1'b1;

      if (fin) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= merge ? (acc_d | placed) : acc_d;
        cnt <= merge ? (cnt_d + CNT_W'(s1_len)) : cnt_d;
      end

      if (drain) begin
        data_out  <= acc[ACC_W-1 -: OUT_W];
        out_nbits <= NB_W'(OUT_W);
        out_valid <= 1'b1;
        out_last  <= 1'b0;
      end else if (fin) begin
        data_out  <= acc[ACC_W-1 -: OUT_W];
        out_nbits <= NB_W'(cnt);
        out_valid <= 1'b1;
        out_last  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (flush && !flush_pending)
        flush_pending <= 1'b1;
      else if (out_valid && out_ready && out_last)
        flush_pending <= 1'b0;
    end
  end
endmodule

// File: tb/tb_huffman_stream_encoder.sv
// Directed + random bench for huffman_stream_encoder; expected words come from a
// bit-queue model of the code stream.
module tb_huffman_stream_encoder;
  logic        clk, rst, enable, tbl_we, in_valid, in_ready, flush;
  logic        out_valid, out_ready, out_last, busy, err_unmapped;
  logic [7:0]  tbl_addr, data_in;
  logic [15:0] tbl_code, data_out;
  logic [4:0]  tbl_len, out_nbits;

  huffman_stream_encoder dut (
    .clk(clk), .rst(rst), .enable(enable), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_code(tbl_code), .tbl_len(tbl_len), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_nbits(out_nbits), .out_last(out_last), .busy(busy),
    .err_unmapped(err_unmapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [15:0] w; int nb; bit last; } exp_t;

  int          n_assert = 0, n_fail = 0, cyc = 0, ov_cyc = -1;
  logic [15:0] mcode [256];
  int          mlen  [256];
  bit          bitq [$];
  exp_t        expq [$];
  int          wcyc [$];
  bit          mpend = 0, merr = 0;
  logic [15:0] lastw;
  int          lastnb;
  logic        lastl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_sym(input int s);
    if (mlen[s] == 0) merr = 1;
    else for (int i = mlen[s] - 1; i >= 0; i--) bitq.push_back(mcode[s][i]);
    while (bitq.size() >= 16) begin
      exp_t e;
      e.w = '0; e.nb = 16; e.last = 0;
      for (int i = 0; i < 16; i++) e.w[15-i] = bitq.pop_front();
      expq.push_back(e);
    end
  endfunction

  function automatic void push_final();
    exp_t e;
    e.w = '0; e.nb = bitq.size(); e.last = 1;
    for (int i = 0; i < e.nb; i++) e.w[15-i] = bitq[i];
    bitq.delete();
    expq.push_back(e);
  endfunction

  // One clock: sample handshakes mid-cycle, advance the edge, update the model.
  task automatic tick(output logic acc);
    logic o, f, l; logic [15:0] w; logic [4:0] nb; logic [7:0] s;
    #2;
    acc = in_valid & in_ready; o = out_valid & out_ready;
    w = data_out; nb = out_nbits; l = out_last; s = data_in; f = flush;
    @(posedge clk); #1; cyc++;
    if (out_valid === 1'b1 && ov_cyc < 0) ov_cyc = cyc;
    if (rst) begin
      bitq.delete(); expq.delete(); mpend = 0; merr = 0;
    end else begin
      if (acc === 1'b1) push_sym(int'(s));
      if (f && !mpend) begin mpend = 1; push_final(); end
      if (o === 1'b1) begin
        lastw = w; lastnb = int'(nb); lastl = l; wcyc.push_back(cyc);
        chk("word_expected", 32'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          exp_t e = expq.pop_front();
          chk("word_data", w, e.w);
          chk("word_nbits", nb, e.nb);
          chk("word_last", l, e.last);
          if (e.last) mpend = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    logic a;
    in_valid = 0; flush = 0; out_ready = 1; enable = 1;
    repeat (n) tick(a);
  endtask

  task automatic wr(input int a, input logic [15:0] c, input int l, input bit apply);
    logic acc;
    tbl_we = 1; tbl_addr = 8'(a); tbl_code = c; tbl_len = 5'(l);
    tick(acc);
    tbl_we = 0;
    if (apply) begin mcode[a] = c; mlen[a] = (l > 16) ? 0 : l; end
  endtask

  task automatic send(input int s);
    logic a;
    a = 0; in_valid = 1; data_in = 8'(s);
    for (int i = 0; i < 50 && a !== 1'b1; i++) tick(a);
    chk("send_accept", a, 1);
  endtask

  task automatic pulse_flush();
    logic a;
    flush = 1; tick(a); flush = 0;
  endtask

  initial begin
    logic a;
    int   n, acc_cyc;
    rst = 1; enable = 1; tbl_we = 0; tbl_addr = 0; tbl_code = 0; tbl_len = 0;
    in_valid = 0; data_in = 0; flush = 0; out_ready = 1;
    tick(a); tick(a);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_unmapped, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_nbits", out_nbits, 0);
    rst = 0; tick(a);
    chk("rst_in_ready", in_ready, 1);

    wr(5, 16'b101, 3, 1); wr(68, 16'h0, 1, 1); wr(50, 16'b11, 2, 1);
    wr(100, 16'hFFFF, 16, 1); wr(200, 16'h7, 0, 1); wr(201, 16'h3, 20, 1);

    // 5,68 x8 -> two 0xAAAA words; the accept edge of the 4th 68 is the first of the
    // three edges, so out_valid rises two clocks after it.
    ov_cyc = -1; wcyc.delete(); acc_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      send(5); send(68);
      if (i == 3) acc_cyc = cyc;
    end
    idle(6);
    chk("latency", 32'(ov_cyc - acc_cyc), 2);
    chk("aaaa_words", 32'(wcyc.size()), 2);
    chk("aaaa_data", lastw, 16'hAAAA);
    chk("aaaa_last", lastl, 0);

    // Flush with 6 bits pending, then flush with nothing pending
    send(50); send(50); send(50); in_valid = 0;
    pulse_flush(); idle(6);
    chk("flush_data", lastw, 16'hFC00);
    chk("flush_nbits", 32'(lastnb), 6);
    chk("flush_last", lastl, 1);
    chk("flush_busy", busy, 0);
    pulse_flush(); idle(4);
    chk("flush0_data", lastw, 16'h0000);
    chk("flush0_nbits", 32'(lastnb), 0);
    chk("flush0_last", lastl, 1);

    // Backpressure with 16-bit codes
    out_ready = 0; in_valid = 1; data_in = 8'd100; n = 0;
    repeat (8) begin tick(a); if (a === 1'b1) n++; end
    chk("bp_accepts", 32'(n), 3);
    chk("bp_in_ready", in_ready, 0);
    wcyc.delete(); in_valid = 0; out_ready = 1;
    idle(6);
    chk("bp_words", 32'(wcyc.size()), 3);
    if (wcyc.size() == 3) begin
      chk("bp_gap0", 32'(wcyc[1] - wcyc[0]), 1);
      chk("bp_gap1", 32'(wcyc[2] - wcyc[1]), 1);
    end
    chk("bp_data", lastw, 16'hFFFF);

    // Unmapped symbols (explicit len 0 and oversized len) are dropped
    send(5); send(200); send(201); send(5); in_valid = 0;
    idle(3);
    chk("err_set", err_unmapped, 1);
    pulse_flush(); idle(6);
    chk("unm_data", lastw, 16'hB400);
    chk("unm_nbits", 32'(lastnb), 6);
    chk("err_sticky", err_unmapped, 1);

    // Reset with a word pending and 7 bits in the accumulator
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin send(5); send(68); end
    send(5); send(68); send(5); in_valid = 0;
    repeat (3) tick(a);
    chk("pre_rst_busy", busy, 1);
    rst = 1; tick(a); rst = 0; out_ready = 1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_unmapped, 0);
    for (int i = 0; i < 4; i++) begin send(5); send(68); end
    in_valid = 0;
    wr(5, 16'b111, 3, 0);  // lands while busy: must be ignored
    idle(6);
    chk("retain_data", lastw, 16'hAAAA);
    for (int i = 0; i < 4; i++) begin send(5); send(68); end
    in_valid = 0; idle(6);
    chk("busy_wr_ignored", lastw, 16'hAAAA);
    chk("dir_drained", 32'(expq.size()), 0);

    // Random table and stream with random stalls, backpressure and flushes
    for (int s = 0; s < 16; s++) wr(s, 16'($urandom), int'($urandom_range(0, 18)), 1);
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      data_in   = 8'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 60) == 0);
      tick(a);
    end
    in_valid = 0; flush = 0; enable = 1; out_ready = 1;
    idle(8);
    pulse_flush(); idle(10);
    chk("rnd_drained", 32'(expq.size()), 0);
    chk("rnd_err", err_unmapped, merr);
    chk("rnd_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
